// File: rtl/can_rx_fifo.sv
// can_rx_fifo
//   Receive-frame queue sitting directly behind the CAN receiver. Each good
//   frame (ID/EXT/RTR/DLC plus 8 data bytes) is stored in a DEPTH-entry FIFO,
//   and the receiver gets an ack pulse so it can clear its frame-available
//   flag. The CPU reads the head frame through a 4-word register window and
//   pops it explicitly with a control write.
//
// Ports
//   clk, rst   : single clock, synchronous active-high reset
//   frm_valid  : 1-cycle pulse, good frame complete; frm_* fields valid
//   frm_id     : 29-bit ID (standard ID in [10:0])
//   frm_ext    : extended-frame flag
//   frm_rtr    : remote-request flag
//   frm_dlc    : data length code
//   frm_data   : data bytes, byte0 in [7:0] .. byte7 in [63:56]
//   src_ack    : 1-cycle pulse one cycle after every frm_valid (stored or dropped)
//   rs, wr, d  : CPU register select, write strobe, write data
//   q          : CPU read data, combinational from rs and the head entry
//   irq        : registered interrupt request
//
// Register window
//   rs=0 : {ext, rtr, 1'b0, id[28:0]}                                  (head)
//   rs=1 : {irqen[1:0], 18'h0, count[3:0], ovf, empty, full, 1'b0, dlc} (ctrl/status)
//   rs=2 : data bytes {b3,b2,b1,b0}                                    (head)
//   rs=3 : data bytes {b7,b6,b5,b4}                                    (head)
//   Write to rs=1: d[0]=pop, d[1]=clear overflow, d[31:30]=irqen.

module can_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm_valid,
  input  logic [28:0] frm_id,
  input  logic        frm_ext,
  input  logic        frm_rtr,
  input  logic [3:0]  frm_dlc,
  input  logic [63:0] frm_data,
  output logic        src_ack,
  input  logic [1:0]  rs,
  input  logic        wr,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        irq
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Entry storage; not reset, contents only meaningful while counted.
  logic [28:0] id_mem   [DEPTH];
  logic        ext_mem  [DEPTH];
  logic        rtr_mem  [DEPTH];
  logic [3:0]  dlc_mem  [DEPTH];
  logic [63:0] data_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    irqen_q, irqen_d;
  logic          src_ack_q;
  logic          irq_q;

  logic empty, full;
  logic ctrl_wr, do_pop, do_push, drop;
  logic [3:0] cnt_field;
  logic unused_d;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DEPTH_CNT);
    ctrl_wr = wr && (rs == 2'd1);
    do_pop  = ctrl_wr && d[0] && !empty;
    // A pop in the same cycle frees the head slot, so a full FIFO can still
    // accept the incoming frame without overflowing.
    do_push = frm_valid && (!full || do_pop);
    drop    = frm_valid && full && !do_pop;
    unused_d = ^d[29:2];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irqen_d  = irqen_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Drop takes priority over a same-cycle clear.
    if (drop)                 ovf_d = 1'b1;
    else if (ctrl_wr && d[1]) ovf_d = 1'b0;
    if (ctrl_wr) irqen_d = d[31:30];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irqen_q   <= 2'b00;
      src_ack_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      irqen_q   <= irqen_d;
      src_ack_q <= frm_valid;
      irq_q     <= (irqen_q[0] && !empty) || (irqen_q[1] && ovf_q);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      id_mem[wr_ptr_q]   <= frm_id;
      ext_mem[wr_ptr_q]  <= frm_ext;
      rtr_mem[wr_ptr_q]  <= frm_rtr;
      dlc_mem[wr_ptr_q]  <= frm_dlc;
      data_mem[wr_ptr_q] <= frm_data;
    end
  end

  always_comb begin
    cnt_field = 4'(count_q);
    q = '0;
    unique case (rs)
      2'd0: if (!empty) q = {ext_mem[rd_ptr_q], rtr_mem[rd_ptr_q], 1'b0, id_mem[rd_ptr_q]};
      2'd1: q = {irqen_q, 18'h0, cnt_field, ovf_q, empty, full, 1'b0,
                 (empty ? 4'h0 : dlc_mem[rd_ptr_q])};
      2'd2: if (!empty) q = data_mem[rd_ptr_q][31:0];
      2'd3: if (!empty) q = data_mem[rd_ptr_q][63:32];
      default: q = '0;
    endcase
  end

  assign src_ack = src_ack_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_can_rx_fifo.sv
module tb_can_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        frm_valid;
  logic [28:0] frm_id;
  logic        frm_ext;
  logic        frm_rtr;
  logic [3:0]  frm_dlc;
  logic [63:0] frm_data;
  logic        src_ack;
  logic [1:0]  rs;
  logic        wr;
  logic [31:0] d;
  logic [31:0] q;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  can_rx_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .frm_valid(frm_valid), .frm_id(frm_id), .frm_ext(frm_ext), .frm_rtr(frm_rtr),
    .frm_dlc(frm_dlc), .frm_data(frm_data), .src_ack(src_ack),
    .rs(rs), .wr(wr), .d(d), .q(q), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the active edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rs(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    rs = sel;
    #1;
    check(tag, q, exp);
  endtask

  task automatic set_frame(input logic [28:0] id, input logic [3:0] dlc, input logic [63:0] data);
    frm_valid = 1'b1;
    frm_id    = id;
    frm_ext   = 1'b0;
    frm_rtr   = 1'b0;
    frm_dlc   = dlc;
    frm_data  = data;
  endtask

  task automatic push(input logic [28:0] id, input logic [3:0] dlc, input logic [63:0] data);
    set_frame(id, dlc, data);
    tick();
    frm_valid = 1'b0;
  endtask

  task automatic ctrl_write(input logic [31:0] val);
    rs = 2'd1; wr = 1'b1; d = val;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frm_valid = 1'b0; frm_id = '0; frm_ext = 1'b0; frm_rtr = 1'b0;
    frm_dlc = '0; frm_data = '0; rs = 2'd0; wr = 1'b0; d = '0;

    // T1 reset, with a frame arriving during reset that must be discarded
    tick();
    set_frame(29'h55, 4'h1, 64'h1);
    tick();
    frm_valid = 1'b0;
    rst = 1'b0;
    check("t1_src_ack", {31'h0, src_ack}, 32'h0);
    check("t1_irq", {31'h0, irq}, 32'h0);
    check_rs("t1_rs1", 2'd1, 32'h0000_0040);
    check_rs("t1_rs0", 2'd0, 32'h0);
    check_rs("t1_rs2", 2'd2, 32'h0);

    // T2 single frame
    frm_ext = 1'b0;
    push(29'h123, 4'h8, 64'h8877_6655_4433_2211);
    check("t2_ack_hi", {31'h0, src_ack}, 32'h1);
    check_rs("t2_rs0", 2'd0, 32'h0000_0123);
    check_rs("t2_rs2", 2'd2, 32'h4433_2211);
    check_rs("t2_rs3", 2'd3, 32'h8877_6655);
    check_rs("t2_rs1", 2'd1, 32'h0000_0108);
    tick();
    check("t2_ack_lo", {31'h0, src_ack}, 32'h0);
    // write to rs=0 must not pop
    rs = 2'd0; wr = 1'b1; d = 32'h1;
    tick();
    wr = 1'b0;
    check_rs("t2_wr_rs0_ignored", 2'd1, 32'h0000_0108);
    ctrl_write(32'h1);
    check_rs("t2_pop_empty", 2'd1, 32'h0000_0040);

    // T3 overflow: five frames into four slots
    for (int unsigned i = 1; i <= 5; i++) begin
      push(29'(i), 4'(i), {32'(i), 32'(i)});
      check($sformatf("t3_ack_%0d", i), {31'h0, src_ack}, 32'h1);
    end
    check_rs("t3_rs1_full_ovf", 2'd1, 32'h0000_04A1);
    for (int unsigned i = 1; i <= 4; i++) begin
      check_rs($sformatf("t3_pop_id_%0d", i), 2'd0, 32'(i));
      check_rs($sformatf("t3_pop_lo_%0d", i), 2'd2, 32'(i));
      ctrl_write(32'h1);
    end
    check_rs("t3_rs1_empty_ovf", 2'd1, 32'h0000_00C0);
    ctrl_write(32'h2);
    check_rs("t3_rs1_ovf_clr", 2'd1, 32'h0000_0040);

    // T4 full, simultaneous push and pop
    for (int unsigned i = 1; i <= 4; i++) push(29'(i), 4'h0, 64'h0);
    check_rs("t4_rs1_full", 2'd1, 32'h0000_0420);
    set_frame(29'h9, 4'h0, 64'h0);
    rs = 2'd1; wr = 1'b1; d = 32'h1;
    tick();
    frm_valid = 1'b0; wr = 1'b0;
    check("t4_ack", {31'h0, src_ack}, 32'h1);
    check_rs("t4_rs1_after", 2'd1, 32'h0000_0420);
    begin
      logic [31:0] exp_ids [4];
      exp_ids[0] = 32'h2; exp_ids[1] = 32'h3; exp_ids[2] = 32'h4; exp_ids[3] = 32'h9;
      for (int unsigned i = 0; i < 4; i++) begin
        check_rs($sformatf("t4_drain_%0d", i), 2'd0, exp_ids[i]);
        ctrl_write(32'h1);
      end
    end
    check_rs("t4_rs1_empty", 2'd1, 32'h0000_0040);

    // T5 pop on empty, push+pop on empty, wrap
    ctrl_write(32'h1);
    check_rs("t5_pop_on_empty", 2'd1, 32'h0000_0040);
    set_frame(29'h77, 4'h3, 64'h0);
    rs = 2'd1; wr = 1'b1; d = 32'h1;
    tick();
    frm_valid = 1'b0; wr = 1'b0;
    check_rs("t5_empty_pushpop_rs1", 2'd1, 32'h0000_0103);
    check_rs("t5_empty_pushpop_id", 2'd0, 32'h0000_0077);
    ctrl_write(32'h1);
    for (int unsigned i = 0; i < 10; i++) begin
      push(29'(32'h10 + i), 4'h0, {32'hA0 + i, 32'hB0 + i});
      check_rs($sformatf("t5_wrap_id_%0d", i), 2'd0, 32'h10 + i);
      check_rs($sformatf("t5_wrap_hi_%0d", i), 2'd3, 32'hA0 + i);
      ctrl_write(32'h1);
    end
    check_rs("t5_rs1_end", 2'd1, 32'h0000_0040);
    // extended frame flags in rs0
    set_frame(29'h1ABC_DEF0, 4'h2, 64'h0);
    frm_ext = 1'b1; frm_rtr = 1'b1;
    tick();
    frm_valid = 1'b0; frm_ext = 1'b0; frm_rtr = 1'b0;
    check_rs("t5_ext_rtr", 2'd0, 32'hDABC_DEF0);
    ctrl_write(32'h1);

    // T6 interrupts
    ctrl_write(32'h4000_0000);
    check("t6_irq_idle", {31'h0, irq}, 32'h0);
    push(29'h5, 4'h0, 64'h0);
    check("t6_irq_1cyc", {31'h0, irq}, 32'h0);
    tick();
    check("t6_irq_ne", {31'h0, irq}, 32'h1);
    ctrl_write(32'h4000_0001);
    tick();
    check("t6_irq_pop", {31'h0, irq}, 32'h0);
    ctrl_write(32'h8000_0000);
    for (int unsigned i = 1; i <= 5; i++) push(29'(i), 4'h0, 64'h0);
    check("t6_irq_ovf_lag", {31'h0, irq}, 32'h0);
    tick();
    check("t6_irq_ovf", {31'h0, irq}, 32'h1);
    // drop in the same cycle as a clear: overflow stays set
    set_frame(29'h6, 4'h0, 64'h0);
    rs = 2'd1; wr = 1'b1; d = 32'h8000_0002;
    tick();
    frm_valid = 1'b0; wr = 1'b0;
    check_rs("t6_drop_wins", 2'd1, 32'h8000_04A0);
    ctrl_write(32'h8000_0002);
    check_rs("t6_ovf_clr", 2'd1, 32'h8000_0420);
    tick();
    check("t6_irq_clr", {31'h0, irq}, 32'h0);

    // mid-stream reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_rs("t7_rst_rs1", 2'd1, 32'h0000_0040);
    check("t7_rst_irq", {31'h0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
